// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types and constants for the data-phase return path.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OWN_S1  = 2'b00,
    OWN_S2  = 2'b01,
    OWN_DEF = 2'b10
  } owner_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OKAY = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  function automatic owner_t decode_owner(input logic dec_valid, input logic decode2mux);
    if (!dec_valid) return OWN_DEF;
    return decode2mux ? OWN_S2 : OWN_S1;
  endfunction

endpackage

// File: rtl/ahb_resp_mux_if.sv
// Bus bundle between master/decoder/slaves and the response mux.
interface ahb_resp_mux_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            HTRANS;
  logic                  DECODE2MUX;
  logic                  DEC_VALID;
  logic [DATA_WIDTH-1:0] HRDATA_S1;
  logic                  HREADYOUT_S1;
  logic                  HRESP_S1;
  logic [DATA_WIDTH-1:0] HRDATA_S2;
  logic                  HREADYOUT_S2;
  logic                  HRESP_S2;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic [1:0]            DATA_OWNER;

  modport slave (
    input  HTRANS, DECODE2MUX, DEC_VALID,
    input  HRDATA_S1, HREADYOUT_S1, HRESP_S1,
    input  HRDATA_S2, HREADYOUT_S2, HRESP_S2,
    output HRDATA, HREADY, HRESP, DATA_OWNER
  );

  modport master (
    output HTRANS, DECODE2MUX, DEC_VALID,
    output HRDATA_S1, HREADYOUT_S1, HRESP_S1,
    output HRDATA_S2, HREADYOUT_S2, HRESP_S2,
    input  HRDATA, HREADY, HRESP, DATA_OWNER
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR for active transfers to unmapped addresses.
//   state   | meaning
//   DS_OKAY | idle / zero-wait OKAY (HREADY=1, HRESP=0)
//   DS_ERR1 | first error cycle      (HREADY=0, HRESP=1)
//   DS_ERR2 | second error cycle     (HREADY=1, HRESP=1)
module ahb_default_slave
  import ahb_lite_pkg::*;
(
  input  logic HCLK,
  input  logic HRESET,
  input  logic HREADY,
  input  logic sel_def,
  input  logic trans_active,
  output logic ds_hready,
  output logic ds_hresp
);

  ds_state_t state_q, state_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= DS_OKAY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    case (state_q)
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = HRESP_ERROR;
      end
      DS_ERR2: ds_hresp = HRESP_ERROR;
      default: ;
    endcase
    // ERR1 always advances; elsewhere a new address phase decides the next response
    if (state_q == DS_ERR1)
      state_d = DS_ERR2;
    else if (HREADY)
      state_d = (sel_def && trans_active) ? DS_ERR1 : DS_OKAY;
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite data-phase response mux: registers the decoder select at each
// accepted address phase and steers the owning slave's response to the master.
module ahb_resp_mux
  import ahb_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic           HCLK,
  input  logic           HRESET,
  ahb_resp_mux_if.slave  bus
);

  owner_t                owner_q;
  owner_t                cap_owner;
  logic                  active_q;
  logic                  cap_active;
  logic                  hready;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  ds_hready;
  logic                  ds_hresp;

  assign cap_owner  = decode_owner(bus.DEC_VALID, bus.DECODE2MUX);
  assign cap_active = (bus.HTRANS == NONSEQ) || (bus.HTRANS == SEQ);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q  <= OWN_DEF;
      active_q <= 1'b0;
    end else if (hready) begin
      owner_q  <= cap_owner;
      active_q <= cap_active;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HREADY       (hready),
    .sel_def      (cap_owner == OWN_DEF),
    .trans_active (cap_active),
    .ds_hready    (ds_hready),
    .ds_hresp     (ds_hresp)
  );

  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    case (owner_q)
      OWN_S1: begin
        hrdata = bus.HRDATA_S1;
        hready = bus.HREADYOUT_S1;
        hresp  = bus.HRESP_S1;
      end
      OWN_S2: begin
        hrdata = bus.HRDATA_S2;
        hready = bus.HREADYOUT_S2;
        hresp  = bus.HRESP_S2;
      end
      default: begin
        // an inactive default data phase is a zero-wait OKAY whatever the FSM holds
        hready = !active_q || ds_hready;
        hresp  = active_q ? ds_hresp : HRESP_OKAY;
      end
    endcase
  end

  assign bus.HRDATA     = hrdata;
  assign bus.HREADY     = hready;
  assign bus.HRESP      = hresp;
  assign bus.DATA_OWNER = owner_q;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_ahb_resp_mux;

  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  ahb_resp_mux_if #(.DATA_WIDTH(32)) bus ();

  ahb_resp_mux #(.DATA_WIDTH(32)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the data phase, whether it was a real transfer,
  // and how many error cycles of the default response remain to be shown.
  int          m_owner;   // 0 = S1, 1 = S2, 2 = default
  bit          m_active;
  int          m_err_left; // 2 = first error cycle pending, 1 = second, 0 = none
  logic [31:0] e_rdata;
  logic        e_ready;
  logic        e_resp;
  logic [1:0]  e_owner;

  task automatic model_out();
    e_owner = 2'(m_owner);
    case (m_owner)
      0: begin e_rdata = bus.HRDATA_S1; e_ready = bus.HREADYOUT_S1; e_resp = bus.HRESP_S1; end
      1: begin e_rdata = bus.HRDATA_S2; e_ready = bus.HREADYOUT_S2; e_resp = bus.HRESP_S2; end
      default: begin
        e_rdata = 32'h0;
        e_ready = (m_err_left != 2);
        e_resp  = (m_err_left != 0);
      end
    endcase
  endtask

  task automatic model_edge();
    if (rst) begin
      m_owner = 2; m_active = 0; m_err_left = 0;
    end else if (m_err_left == 2) begin
      m_err_left = 1;
    end else if (e_ready) begin
      m_owner    = !bus.DEC_VALID ? 2 : (bus.DECODE2MUX ? 1 : 0);
      m_active   = bus.HTRANS[1];
      m_err_left = (m_owner == 2 && m_active) ? 2 : 0;
    end
  endtask

  task automatic tick();
    model_out();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] tr, input logic v, input logic d,
                        input logic [31:0] d1, input logic r1, input logic e1,
                        input logic [31:0] d2, input logic r2, input logic e2);
    bus.HTRANS = tr; bus.DEC_VALID = v; bus.DECODE2MUX = d;
    bus.HRDATA_S1 = d1; bus.HREADYOUT_S1 = r1; bus.HRESP_S1 = e1;
    bus.HRDATA_S2 = d2; bus.HREADYOUT_S2 = r2; bus.HRESP_S2 = e2;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(2'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom),
           $urandom, 1'($urandom), 1'($urandom));
    tick();
    tick();
    n_cmp++; if (bus.HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got %h exp 0", bus.HRDATA); end
    n_cmp++; if (bus.HREADY !== 1'b1) begin n_fail++; $display("FAIL reset_hready got %b exp 1", bus.HREADY); end
    n_cmp++; if (bus.HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_hresp got %b exp 0", bus.HRESP); end
    n_cmp++; if (bus.DATA_OWNER !== 2'b10) begin n_fail++; $display("FAIL reset_owner got %b exp 10", bus.DATA_OWNER); end
    rst = 1'b0;
  endtask

  task automatic test_s1_read();
    set_in(2'b10, 1, 0, $urandom, 0, 1, $urandom, 0, 1);
    tick();
    // unselected S2 bus floats to X; nothing of it may reach the outputs
    set_in(2'b00, 1, 0, 32'hDEADBEEF, 1, 0, 'x, 1'bx, 1'bx);
    n_cmp++; if (bus.HRDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL s1_hrdata got %h exp deadbeef", bus.HRDATA); end
    n_cmp++; if (bus.HREADY !== 1'b1) begin n_fail++; $display("FAIL s1_hready got %b exp 1", bus.HREADY); end
    n_cmp++; if (bus.HRESP !== 1'b0) begin n_fail++; $display("FAIL s1_hresp got %b exp 0", bus.HRESP); end
    n_cmp++; if (bus.DATA_OWNER !== 2'b00) begin n_fail++; $display("FAIL s1_owner got %b exp 00", bus.DATA_OWNER); end
    tick();
  endtask

  task automatic test_s2_wait();
    logic [31:0] junk;
    set_in(2'b10, 1, 1, $urandom, 1, 0, $urandom, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      junk = $urandom;
      set_in(2'b10, 1, 0, junk, 1'($urandom), 1'($urandom), 32'h12345678, (i == 2), 0);
      n_cmp++; if (bus.HREADY !== (i == 2)) begin n_fail++; $display("FAIL s2_wait_hready cyc%0d got %b exp %b", i, bus.HREADY, (i == 2)); end
      n_cmp++; if (bus.DATA_OWNER !== 2'b01) begin n_fail++; $display("FAIL s2_wait_owner cyc%0d got %b exp 01", i, bus.DATA_OWNER); end
      tick();
    end
    n_cmp++; if (bus.HRDATA === 32'h12345678 && bus.DATA_OWNER !== 2'b00) begin n_fail++; $display("FAIL s2_wait_data got %h", bus.HRDATA); end
    set_in(2'b00, 1, 0, 32'hA5A5_0001, 1, 0, 32'h12345678, 1, 0);
    n_cmp++; if (bus.DATA_OWNER !== 2'b00) begin n_fail++; $display("FAIL s2_after_owner got %b exp 00", bus.DATA_OWNER); end
    n_cmp++; if (bus.HRDATA !== 32'hA5A5_0001) begin n_fail++; $display("FAIL s2_after_hrdata got %h exp a5a50001", bus.HRDATA); end
    tick();
  endtask

  task automatic test_unmapped_err();
    set_in(2'b10, 0, 1'($urandom), $urandom, 1, 0, $urandom, 1, 0);
    tick();
    set_in(2'b00, 0, 0, $urandom, 1, 1, $urandom, 1, 1);
    n_cmp++; if ({bus.HREADY, bus.HRESP} !== 2'b01) begin n_fail++; $display("FAIL err1 ready/resp got %b%b exp 01", bus.HREADY, bus.HRESP); end
    n_cmp++; if (bus.HRDATA !== 32'h0) begin n_fail++; $display("FAIL err1_hrdata got %h exp 0", bus.HRDATA); end
    tick();
    n_cmp++; if ({bus.HREADY, bus.HRESP} !== 2'b11) begin n_fail++; $display("FAIL err2 ready/resp got %b%b exp 11", bus.HREADY, bus.HRESP); end
    tick();
    n_cmp++; if ({bus.HREADY, bus.HRESP} !== 2'b10) begin n_fail++; $display("FAIL err_done ready/resp got %b%b exp 10", bus.HREADY, bus.HRESP); end
  endtask

  task automatic test_idle_and_b2b();
    logic [1:0] exp_seq [4] = '{2'b01, 2'b11, 2'b01, 2'b11};
    set_in(2'b00, 0, 0, $urandom, 1, 0, $urandom, 1, 0);
    tick();
    n_cmp++; if ({bus.HREADY, bus.HRESP} !== 2'b10) begin n_fail++; $display("FAIL idle_def ready/resp got %b%b exp 10", bus.HREADY, bus.HRESP); end
    set_in(2'b10, 0, 0, $urandom, 1, 0, $urandom, 1, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) set_in(2'b00, 0, 0, $urandom, 1, 0, $urandom, 1, 0);
      n_cmp++; if ({bus.HREADY, bus.HRESP} !== exp_seq[i]) begin n_fail++; $display("FAIL b2b cyc%0d got %b%b exp %b", i, bus.HREADY, bus.HRESP, exp_seq[i]); end
      tick();
    end
    n_cmp++; if ({bus.HREADY, bus.HRESP} !== 2'b10) begin n_fail++; $display("FAIL b2b_done got %b%b exp 10", bus.HREADY, bus.HRESP); end
  endtask

  task automatic test_reset_mid_err();
    set_in(2'b11, 0, 1, $urandom, 1, 0, $urandom, 1, 0);
    tick();
    n_cmp++; if ({bus.HREADY, bus.HRESP} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_err1 got %b%b exp 01", bus.HREADY, bus.HRESP); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(2'b00, 1, 1, $urandom, 1, 0, $urandom, 1, 0);
    n_cmp++; if ({bus.HREADY, bus.HRESP} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_err ready/resp got %b%b exp 10", bus.HREADY, bus.HRESP); end
    n_cmp++; if (bus.DATA_OWNER !== 2'b10) begin n_fail++; $display("FAIL rst_mid_err_owner got %b exp 10", bus.DATA_OWNER); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      set_in(2'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
             $urandom, ($urandom_range(0, 2) != 0), 1'($urandom),
             $urandom, ($urandom_range(0, 2) != 0), 1'($urandom));
      model_out();
      n_cmp++; if (bus.HRDATA !== e_rdata) begin n_fail++; $display("FAIL rnd_hrdata cyc%0d got %h exp %h", i, bus.HRDATA, e_rdata); end
      n_cmp++; if (bus.HREADY !== e_ready) begin n_fail++; $display("FAIL rnd_hready cyc%0d got %b exp %b", i, bus.HREADY, e_ready); end
      n_cmp++; if (bus.HRESP !== e_resp) begin n_fail++; $display("FAIL rnd_hresp cyc%0d got %b exp %b", i, bus.HRESP, e_resp); end
      n_cmp++; if (bus.DATA_OWNER !== e_owner) begin n_fail++; $display("FAIL rnd_owner cyc%0d got %b exp %b", i, bus.DATA_OWNER, e_owner); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_owner = 2; m_active = 0; m_err_left = 0;
    test_reset();
    test_s1_read();
    test_s2_wait();
    test_unmapped_err();
    test_idle_and_b2b();
    test_reset_mid_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux.md
Name: ahb_resp_mux

Overview:
- Data-phase return path of the AHB-Lite interconnect; sits directly downstream of the address decoder.
- Registers the decoder's slave select (DECODE2MUX, DEC_VALID) at each address phase.
- In the following data phase, steers the owning slave's HRDATA/HREADYOUT/HRESP back to the master.
- Contains a built-in default slave that returns the two-cycle ERROR response for active transfers to unmapped addresses.

Parameters:
- DATA_WIDTH, 32, width of HRDATA buses.

Ports:
- HCLK  in  1  system clock; all state updates on rising edge.
- HRESET  in  1  reset; one clock; synchronous, active-high.
- HTRANS  in  2  address-phase transfer type from master.
- DECODE2MUX  in  1  decoder slave select: 0 = slave 1, 1 = slave 2.
- DEC_VALID  in  1  1 = address maps to slave 1 or slave 2; 0 = unmapped (default slave).
- HRDATA_S1  in  DATA_WIDTH  slave 1 read data.
- HREADYOUT_S1  in  1  slave 1 ready.
- HRESP_S1  in  1  slave 1 response (0 OKAY, 1 ERROR).
- HRDATA_S2  in  DATA_WIDTH  slave 2 read data.
- HREADYOUT_S2  in  1  slave 2 ready.
- HRESP_S2  in  1  slave 2 response.
- HRDATA  out  DATA_WIDTH  read data to master.
- HREADY  out  1  global ready to master and all slaves.
- HRESP  out  1  response to master.
- DATA_OWNER  out  2  current data-phase owner: 00 = S1, 01 = S2, 10 = DEFAULT.

Behaviour:
- Address-phase capture occurs only on a rising edge where HREADY=1:
  - owner_q <= DEC_VALID ? (DECODE2MUX ? S2 : S1) : DEFAULT.
  - active_q <= HTRANS[1] (NONSEQ/SEQ = active; IDLE/BUSY = inactive).
- While HREADY=0, owner_q and active_q hold. Address-phase inputs presented during wait states are ignored.
- Output mux is combinational from registered state; no added latency.
  - owner S1: HRDATA/HREADY/HRESP = the S1 inputs.
  - owner S2: HRDATA/HREADY/HRESP = the S2 inputs.
  - owner DEFAULT: HRDATA = 0; HREADY/HRESP come from the default-slave FSM.
- Default-slave FSM states: DS_OKAY, DS_ERR1, DS_ERR2.
  - DS_OKAY: HREADY=1, HRESP=0.
  - DS_ERR1: HREADY=0, HRESP=1.
  - DS_ERR2: HREADY=1, HRESP=1.
- FSM transitions:
  - Any state where HREADY=1 and the capture selects DEFAULT with active → DS_ERR1.
  - DS_ERR1 → DS_ERR2 unconditionally.
  - Any state where HREADY=1 and the capture is not (DEFAULT and active) → DS_OKAY.
- Inactive (IDLE/BUSY) transfers to DEFAULT give a zero-wait OKAY.
- Slave ERROR responses pass through unmodified. Slaves own their own two-cycle sequencing.
- Back-to-back errors: an invalid active capture in DS_ERR2 (HREADY=1) goes directly to DS_ERR1. No OKAY cycle is inserted.
- Reset (HRESET=1 sampled at an edge):
  - owner_q=DEFAULT, active_q=0, FSM=DS_OKAY.
  - Outputs become HRDATA=0, HREADY=1, HRESP=0, DATA_OWNER=10.
  - Reset applies even mid-wait-state or mid-ERR1; any in-flight data phase is abandoned.
- DECODE2MUX is a don't-care when DEC_VALID=0.
- DATA_OWNER=11 is never driven.
- No X propagation from unselected slave buses into any output.

Decomposition:
- Shared package ahb_lite_pkg:
  - htrans_t enum: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - owner_t enum: OWN_S1=2'b00, OWN_S2=2'b01, OWN_DEF=2'b10.
  - Constants HRESP_OKAY=1'b0, HRESP_ERROR=1'b1.
  - ds_state_t for the FSM.
- One natural sub-module: ahb_default_slave.
  - Inputs: HCLK, HRESET, HREADY, sel_def, trans_active.
  - Outputs: ds_hready, ds_hresp.
  - Holds the three-state FSM.
- The top level holds the capture registers and the output mux.

Test Plan:
1. Reset: hold HRESET=1 for 2 cycles, with garbage on all slave inputs → HRDATA=0, HREADY=1, HRESP=0, DATA_OWNER=10.
2. Slave 1 zero-wait read: HTRANS=NONSEQ, DEC_VALID=1, DECODE2MUX=0; next cycle HRDATA_S1=32'hDEADBEEF, HREADYOUT_S1=1 → HRDATA=32'hDEADBEEF, HREADY=1, HRESP=0, DATA_OWNER=00.
3. Slave 2 wait states: NONSEQ to S2, then HREADYOUT_S2=0,0,1 with HRDATA_S2=32'h12345678. During the waits, present NONSEQ with DECODE2MUX=0 → HREADY=0,0,1; DATA_OWNER stays 01 for 3 cycles; becomes 00 on the following cycle.
4. Unmapped active transfer: NONSEQ with DEC_VALID=0, followed by IDLE → next cycle HREADY=0, HRESP=1; next HREADY=1, HRESP=1; next HREADY=1, HRESP=0.
5. Unmapped IDLE and back-to-back errors:
   - IDLE with DEC_VALID=0 → HREADY=1, HRESP=0 (zero wait).
   - Two consecutive invalid NONSEQs (the second held until the ERR2 cycle) → ERR1, ERR2, ERR1, ERR2.
6. Reset mid-error: assert HRESET during the DS_ERR1 cycle → next cycle HREADY=1, HRESP=0, DATA_OWNER=10; no ERR2 cycle occurs.
